// File: rtl/crc_sysid_pkg.sv
// ============================================================================
// crc_sysid_pkg: shared state encoding and sysid slave constants | rev 1.0
// ============================================================================
`default_nettype none

package crc_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Regenerated with the system build; the checker default follows it.
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1713864293;

endpackage

`default_nettype wire

// File: rtl/crc_sysid_timeout_ctr.sv
// ============================================================================
// crc_sysid_timeout_ctr: stall counter that flags the cycle reaching limit | rev 1.0
// ============================================================================
`default_nettype none

module crc_sysid_timeout_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Fires in the stalled cycle whose increment would bring the count to limit.
  assign expired = enable && (({1'b0, count} + 17'd1) == {1'b0, limit});

endmodule

`default_nettype wire

// File: rtl/crc_sysid_checker.sv
// ============================================================================
// crc_sysid_checker: Avalon-MM master that reads and verifies the system ID | rev 1.0
// ============================================================================
`default_nettype none

module crc_sysid_checker
  import crc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          CHECK_ON_RESET     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t state;
  state_t state_next;
  logic   auto_pending;
  logic   read_active;
  logic   read_done;
  logic   read_next;
  logic   expired;

  assign read_active = (state == RD_ID) || (state == RD_TS);
  assign read_done   = read_active && !avm_waitrequest;
  assign read_next   = (state_next == RD_ID) || (state_next == RD_TS);

  crc_sysid_timeout_ctr u_timeout_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!read_active || read_done),
    .enable  (read_active && avm_waitrequest),
    .limit   (TIMEOUT_LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start || auto_pending) begin
          state_next = RD_ID;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          state_next = RD_TS;
        end else if (expired) begin
          state_next = DONE;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest || expired) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes and status are registered from the next state so they are glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pending <= CHECK_ON_RESET;
      avm_read     <= 1'b0;
      avm_address  <= SYSID_ADDR_ID;
      busy         <= 1'b0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
    end else begin
      avm_read    <= read_next;
      avm_address <= (state_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy        <= read_next;
      done        <= (state_next == DONE);

      if ((state == IDLE) && (state_next == RD_ID)) begin
        auto_pending <= 1'b0;
        id_ok        <= 1'b0;
        ts_ok        <= 1'b0;
        timeout      <= 1'b0;
        id_value     <= 32'd0;
        ts_value     <= 32'd0;
      end

      if ((state == RD_ID) && read_done) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end

      if ((state == RD_TS) && read_done) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end

      if (expired) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crc_sysid_checker.sv
// ============================================================================
// tb_crc_sysid_checker: table-driven and scoreboarded bench for the checker | rev 1.0
// ============================================================================
`default_nettype none

module tb_crc_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1713864293;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] id_data = 32'd0;
  logic [31:0] ts_data = TS_GOOD;
  int          id_stall = 0;
  int          ts_stall = 0;
  int          stall_cnt;

  always #5 clock = ~clock;

  crc_sysid_checker #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (TS_GOOD),
    .TIMEOUT_CYCLES     (8),
    .CHECK_ON_RESET     (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  // Sysid slave model: stalls a configurable number of cycles per read.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt <= 0;
    else if (avm_read && !avm_waitrequest) stall_cnt <= 0;
    else if (avm_read) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  assign avm_waitrequest = avm_read && (stall_cnt < (avm_address ? ts_stall : id_stall));
  assign avm_readdata    = avm_address ? ts_data : id_data;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } exp_t;

  typedef struct {
    logic [31:0] id_data;
    logic [31:0] ts_data;
    int          id_stall;
    int          ts_stall;
    logic        e_id_ok;
    logic        e_ts_ok;
    logic        e_to;
    int          e_lat;
    int          e_nreads;
  } vec_t;

  exp_t exp_q[$];
  logic addr_log[$];
  vec_t vecs[12];

  int   tests = 0;
  int   fails = 0;
  int   rd_cycles = 0;
  int   busy_cycles = 0;
  int   done_pulses = 0;
  logic prev_read = 1'b0;
  logic prev_wait = 1'b0;
  logic prev_addr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (reset_n) begin
      if (avm_read) rd_cycles++;
      if (busy) busy_cycles++;
      if (avm_read && prev_read && prev_wait) check("addr_stable", 32'(avm_address), 32'(prev_addr));
      if (avm_read && !avm_waitrequest) addr_log.push_back(avm_address);
      if (done) begin
        done_pulses++;
        check("done_expected", 32'(exp_q.size()), 32'd1);
        check("done_cycle_busy_read", 32'({busy, avm_read}), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("id_ok", 32'(id_ok), 32'(e.id_ok));
          check("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
          check("timeout", 32'(timeout), 32'(e.tmo));
          check("id_value", id_value, e.id_value);
          check("ts_value", ts_value, e.ts_value);
        end
      end
      prev_read = avm_read;
      prev_wait = avm_waitrequest;
      prev_addr = avm_address;
    end else begin
      prev_read = 1'b0;
      prev_wait = 1'b0;
      prev_addr = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    repeat (200) begin
      tick();
      start = 1'b0;
      lat++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic push_exp(input logic i_ok, input logic t_ok, input logic tmo,
                          input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    e.id_ok = i_ok; e.ts_ok = t_ok; e.tmo = tmo; e.id_value = idv; e.ts_value = tsv;
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    rd_cycles = 0;
    busy_cycles = 0;
    addr_log.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_ctl"}, 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
    check({name, "_id_value"}, id_value, 32'd0);
    check({name, "_ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses_before;
    logic [31:0] idv;
    logic [31:0] tsv;

    vecs[0]  = '{32'd0,        TS_GOOD,                 0,    0, 1'b1, 1'b1, 1'b0,  3, 2};
    vecs[1]  = '{32'd0,        TS_GOOD,                 4,    4, 1'b1, 1'b1, 1'b0, 11, 2};
    vecs[2]  = '{32'd0,        32'd1713864294,          0,    0, 1'b1, 1'b0, 1'b0,  3, 2};
    vecs[3]  = '{32'd5,        TS_GOOD,                 1,    2, 1'b0, 1'b1, 1'b0,  6, 2};
    vecs[4]  = '{32'd0,        TS_GOOD,                 7,    0, 1'b1, 1'b1, 1'b0, 10, 2};
    vecs[5]  = '{32'd0,        TS_GOOD,                 8,    0, 1'b0, 1'b0, 1'b1,  9, 0};
    vecs[6]  = '{32'd0,        TS_GOOD,              1000,    0, 1'b0, 1'b0, 1'b1,  9, 0};
    vecs[7]  = '{32'd0,        TS_GOOD,                 0,    7, 1'b1, 1'b1, 1'b0, 10, 2};
    vecs[8]  = '{32'd0,        TS_GOOD,                 0,    8, 1'b1, 1'b0, 1'b1, 10, 1};
    vecs[9]  = '{32'hFFFFFFFF, 32'd0,                   0,    0, 1'b0, 1'b0, 1'b0,  3, 2};
    vecs[10] = '{32'd1,        TS_GOOD ^ 32'h80000000,  0,    0, 1'b0, 1'b0, 1'b0,  3, 2};
    vecs[11] = '{32'd0,        TS_GOOD,                 2,    5, 1'b1, 1'b1, 1'b0, 10, 2};

    // Reset state, then the automatic check after release.
    tick(); tick();
    check_zero_outputs("reset");
    clear_counts();
    push_exp(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
    reset_n = 1'b1;
    wait_done(lat);
    check("auto_latency", 32'(lat), 32'd3);
    check("auto_rd_cycles", 32'(rd_cycles), 32'd2);
    for (int k = 0; k < addr_log.size(); k++) check("auto_rd_addr", 32'(addr_log[k]), 32'(k));
    check("auto_nreads", 32'(addr_log.size()), 32'd2);

    for (int i = 0; i < 12; i++) begin
      tick();
      id_data  = vecs[i].id_data;
      ts_data  = vecs[i].ts_data;
      id_stall = vecs[i].id_stall;
      ts_stall = vecs[i].ts_stall;
      idv = (vecs[i].e_nreads >= 1) ? vecs[i].id_data : 32'd0;
      tsv = (vecs[i].e_nreads == 2) ? vecs[i].ts_data : 32'd0;
      push_exp(vecs[i].e_id_ok, vecs[i].e_ts_ok, vecs[i].e_to, idv, tsv);
      clear_counts();
      start = 1'b1;
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
      check($sformatf("v%0d_rd_cycles", i), 32'(rd_cycles), 32'(vecs[i].e_lat - 1));
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_cycles), 32'(vecs[i].e_lat - 1));
      check($sformatf("v%0d_nreads", i), 32'(addr_log.size()), 32'(vecs[i].e_nreads));
      for (int k = 0; k < addr_log.size(); k++)
        check($sformatf("v%0d_rd_addr", i), 32'(addr_log[k]), 32'(k));
      tick();
      check($sformatf("v%0d_idle", i), 32'({busy, done, avm_read}), 32'd0);
    end

    // start during RD_TS is ignored: one done pulse only.
    id_data = 32'd0; ts_data = TS_GOOD; id_stall = 0; ts_stall = 4;
    push_exp(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
    pulses_before = done_pulses;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("in_rd_ts", 32'({avm_read, avm_address, busy}), 32'b111);
    start = 1'b1;
    wait_done(lat);
    check("ignored_start_latency", 32'(lat), 32'd5);
    repeat (6) tick();
    check("ignored_start_pulses", 32'(done_pulses - pulses_before), 32'd1);
    check("ignored_start_queue", 32'(exp_q.size()), 32'd0);

    // A following start clears the sticky flags on entry and re-runs.
    ts_stall = 3;
    push_exp(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
    start = 1'b1; tick(); start = 1'b0;
    check("rerun_flags_cleared", 32'({id_ok, ts_ok, timeout, busy}), 32'b0001);
    check("rerun_id_value_cleared", id_value, 32'd0);
    wait_done(lat);
    check("rerun_latency", 32'(lat), 32'd5);

    // Asynchronous reset in the middle of the timestamp read.
    tick();
    ts_stall = 5;
    push_exp(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("pre_reset_rd_ts", 32'({avm_read, avm_address}), 32'b11);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    exp_q.delete();
    tick(); tick();
    ts_stall = 0;
    clear_counts();
    push_exp(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD);
    reset_n = 1'b1;
    wait_done(lat);
    check("post_reset_latency", 32'(lat), 32'd3);
    check("post_reset_nreads", 32'(addr_log.size()), 32'd2);
    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc_sysid_checker.md
Name: crc_sysid_checker

Overview:
Avalon-MM read master that interrogates the system-ID slave across the interconnect. It reads the ID word (address 0) and the timestamp word (address 1), then compares both against expected values. The result is reported as sticky pass/fail flags and a one-cycle done pulse. It sits beside the CPU subsystem as a hardware boot-integrity check, so mismatched software/hardware builds are flagged without CPU involvement.

Parameters:
EXPECTED_ID, 32'd0, value the ID word (address 0) must return
EXPECTED_TIMESTAMP, 32'd1713864293, value the timestamp word (address 1) must return
TIMEOUT_CYCLES, 255, maximum cycles one read may stall on waitrequest before abort (1..65535)
CHECK_ON_RESET, 1, 1 = start a check automatically in the first cycle after reset release

Ports:
clock  input  1  system clock, all logic rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to run a check; ignored while busy
avm_address  output  1  word address to sysid slave (0 = ID, 1 = timestamp)
avm_read  output  1  read strobe
avm_waitrequest  input  1  slave stall; read completes in the cycle this is low while avm_read is high
avm_readdata  input  32  read data, valid in the completing cycle
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at check completion (pass, fail or timeout)
id_ok  output  1  sticky: ID word matched EXPECTED_ID
ts_ok  output  1  sticky: timestamp matched EXPECTED_TIMESTAMP
timeout  output  1  sticky: a read exceeded TIMEOUT_CYCLES
id_value  output  32  captured ID word
ts_value  output  32  captured timestamp word

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE. All outputs are 0, including avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value and the timeout counter.
- FSM states: IDLE, RD_ID, RD_TS, DONE.
- IDLE -> RD_ID on start=1, or one cycle after reset release if CHECK_ON_RESET=1 (fires once per reset).
  - Entering RD_ID clears id_ok, ts_ok, timeout, id_value and ts_value, and sets busy.
- RD_ID: avm_read=1, avm_address=0, both registered and held stable while avm_waitrequest=1.
  - Completing cycle (avm_waitrequest=0): capture id_value <= avm_readdata; id_ok <= (avm_readdata == EXPECTED_ID); go to RD_TS.
  - avm_read is registered, so back-to-back reads are separated by at most 0 idle cycles. The address changes to 1 in the cycle after completion.
- RD_TS: avm_read=1, avm_address=1.
  - On completion: capture ts_value and set ts_ok by the same comparison against EXPECTED_TIMESTAMP; go to DONE.
- Timeout: a 16-bit counter clears on entry to each read state and increments each cycle avm_waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES while still stalled: deassert avm_read next cycle, set timeout=1, go to DONE.
  - The ok flag for the aborted read stays 0; the remaining read is skipped.
- DONE: one cycle. done=1, busy=0 and avm_read=0 in that cycle, then return to IDLE. Flags hold until the next check starts.
- Minimum latency with zero-wait slave: start at cycle N -> avm_read high N+1, N+2 -> done high at N+3.
- start while busy (RD_ID, RD_TS, DONE): ignored, not queued.
- Reset mid-read: avm_read drops immediately (asynchronous). A slave must tolerate an abandoned read.
- Comparisons are full 32-bit equality; no masking.

Decomposition:
- Shared package crc_sysid_pkg holds:
  - FSM state encoding (2-bit enum IDLE=0, RD_ID=1, RD_TS=2, DONE=3)
  - address constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1
  - default EXPECTED_TIMESTAMP constant, so system generation updates one place
- One natural sub-module: crc_sysid_timeout_ctr (clear, enable, limit in; expired out), reusable by other masters.
- FSM, capture registers and compare stay in the top level.

Test Plan:
- Zero-wait slave returns 0 then 1713864293, CHECK_ON_RESET=1 -> reads at addr 0 then 1 on consecutive cycles; done pulses 3 cycles after reset release; id_ok=1, ts_ok=1, timeout=0.
- Slave holds waitrequest 4 cycles per read, start pulse -> avm_address/avm_read stable during stall; done at start+11 cycles; flags both 1.
- Slave returns timestamp 1713864294 -> ts_ok=0, id_ok=1, ts_value=1713864294, done pulses once.
- TIMEOUT_CYCLES=8, slave holds waitrequest permanently on addr 0 -> avm_read drops after 8 stalled cycles; timeout=1, id_ok=0, ts_ok=0; no addr-1 read issued.
- start pulsed again during RD_TS -> ignored; exactly one done pulse. A following start clears the flags and re-runs the check.
- reset_n asserted mid-RD_TS -> all outputs 0 asynchronously. After release with CHECK_ON_RESET=1, a fresh check runs and completes.
